// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared state enum, opcode/ext constants, flag indices and branch conditions
package cpu_pkg;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_RTYPE    = 4'h0;
    localparam logic [3:0] OP_ITYPE_LO = 4'h1;
    localparam logic [3:0] OP_ITYPE_HI = 4'h7;
    localparam logic [3:0] OP_CMP      = 4'h3;
    localparam logic [3:0] OP_MEM      = 4'h8;
    localparam logic [3:0] OP_BCOND    = 4'hC;
    localparam logic [3:0] OP_HALT     = 4'hF;

    localparam logic [3:0] EXT_LOAD  = 4'h0;
    localparam logic [3:0] EXT_STORE = 4'h4;

    // Flags port is {C,L,F,Z,N}
    localparam int FLAG_N = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_F = 2;
    localparam int FLAG_L = 3;
    localparam int FLAG_C = 4;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_UC = 4'hE;

endpackage

// File: rtl/branch_cond.sv
// rtl/branch_cond.sv - maps a branch condition code and the flag register to a taken decision
module branch_cond
    import cpu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [4:0] flags,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_EQ: taken = flags[FLAG_Z];
            COND_NE: taken = !flags[FLAG_Z];
            COND_CS: taken = flags[FLAG_C];
            COND_CC: taken = !flags[FLAG_C];
            COND_UC: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    // N, F and L never steer a branch
    logic unused_flags;
    assign unused_flags = ^{flags[FLAG_N], flags[FLAG_F], flags[FLAG_L]};

endmodule

// File: rtl/cpu_controller.sv
// rtl/cpu_controller.sv - multi-cycle Moore control FSM; BRANCH_EN adds conditional pc-relative branches
module cpu_controller
    import cpu_pkg::*;
#(
    parameter logic [9:0] PC_RESET  = 10'h000,
    parameter logic [9:0] DATA_BASE = 10'h200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] instr,
    input  logic [15:0] src_data,
    input  logic [4:0]  Flags,
    output logic [3:0]  DestCtrl,
    output logic [3:0]  SrcCtrl,
    output logic [3:0]  operation,
    output logic [7:0]  immediate,
    output logic        immEn,
    output logic        flagsEn,
    output logic        reg_we,
    output logic [9:0]  AddressA,
    output logic [9:0]  AddressB,
    output logic        RWA,
    output logic        RWB,
    output logic        AorB,
    output logic        AluOrMem,
    output logic [9:0]  pc,
    output logic        halted
);

    state_t      state_q, state_d;
    logic [9:0]  pc_q, pc_d;
    logic [15:0] ir_q, ir_d;

    logic [3:0] op, rd, ext, rs;
    logic [7:0] imm;
    logic [9:0] mem_addr;

    assign op       = ir_q[15:12];
    assign rd       = ir_q[11:8];
    assign ext      = ir_q[7:4];
    assign rs       = ir_q[3:0];
    assign imm      = ir_q[7:0];
    assign mem_addr = DATA_BASE + src_data[9:0];

`ifdef BRANCH_EN
    logic br_taken;

    branch_cond u_branch_cond (
        .cond  (rd),
        .flags (Flags),
        .taken (br_taken)
    );

    logic unused_inputs;
    assign unused_inputs = ^src_data[15:10];
`else
    logic unused_inputs;
    assign unused_inputs = ^{src_data[15:10], Flags};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= PC_RESET;
            ir_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        DestCtrl  = 4'h0;
        SrcCtrl   = 4'h0;
        operation = 4'h0;
        immediate = 8'h00;
        immEn     = 1'b0;
        flagsEn   = 1'b0;
        reg_we    = 1'b0;
        AddressA  = 10'h000;
        AddressB  = pc_q;
        RWA       = 1'b0;
        RWB       = 1'b0;
        AorB      = 1'b1;
        AluOrMem  = 1'b1;

        case (state_q)
            S_FETCH: begin
                AddressB = pc_q;
                state_d  = S_DECODE;
            end
            S_DECODE: begin
                ir_d    = instr;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                pc_d    = pc_q + 10'd1;
                state_d = S_FETCH;
                if (op == OP_RTYPE) begin
                    DestCtrl  = rd;
                    SrcCtrl   = rs;
                    operation = ext;
                    reg_we    = 1'b1;
                    flagsEn   = 1'b1;
                end else if (op >= OP_ITYPE_LO && op <= OP_ITYPE_HI) begin
                    DestCtrl  = rd;
                    operation = op;
                    immediate = imm;
                    immEn     = 1'b1;
                    reg_we    = (op != OP_CMP);
                    flagsEn   = 1'b1;
                end else if (op == OP_MEM) begin
                    state_d = S_MEM;
                end else if (op == OP_HALT) begin
                    state_d = S_HALT;
`ifdef BRANCH_EN
                end else if (op == OP_BCOND && br_taken) begin
                    // displacement is relative to the branch's own address
                    pc_d = pc_q + {{2{imm[7]}}, imm};
`endif
                end
            end
            S_MEM: begin
                SrcCtrl  = rs;
                DestCtrl = rd;
                AddressA = mem_addr;
                if (ext == EXT_LOAD) begin
                    state_d = S_WB;
                end else begin
                    RWA     = (ext == EXT_STORE);
                    state_d = S_FETCH;
                end
            end
            S_WB: begin
                AluOrMem = 1'b0;
                AorB     = 1'b1;
                DestCtrl = rd;
                reg_we   = 1'b1;
                state_d  = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    assign pc     = pc_q;
    assign halted = (state_q == S_HALT);

endmodule

// File: tb/tb_cpu_controller.sv
// tb/tb_cpu_controller.sv - vector table, hand sequences and random instruction stream against an instruction-level model
module tb_cpu_controller;

    localparam logic [9:0] PC_RESET  = 10'h000;
    localparam logic [9:0] DATA_BASE = 10'h200;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instr, src_data;
    logic [4:0]  Flags;
    logic [3:0]  DestCtrl, SrcCtrl, operation;
    logic [7:0]  immediate;
    logic        immEn, flagsEn, reg_we;
    logic [9:0]  AddressA, AddressB;
    logic        RWA, RWB, AorB, AluOrMem;
    logic [9:0]  pc;
    logic        halted;

    cpu_controller #(.PC_RESET(PC_RESET), .DATA_BASE(DATA_BASE)) dut (
        .clk(clk), .reset(reset), .instr(instr), .src_data(src_data), .Flags(Flags),
        .DestCtrl(DestCtrl), .SrcCtrl(SrcCtrl), .operation(operation), .immediate(immediate),
        .immEn(immEn), .flagsEn(flagsEn), .reg_we(reg_we), .AddressA(AddressA), .AddressB(AddressB),
        .RWA(RWA), .RWB(RWB), .AorB(AorB), .AluOrMem(AluOrMem), .pc(pc), .halted(halted)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [9:0] m_pc;

    logic [3:0] x_dest, x_src, x_op;
    logic [7:0] x_imm;
    logic       x_immen, x_we, x_fl;
    logic [9:0] x_addra;
    int         x_rwa;

    typedef struct {
        logic [15:0] iw;
        logic        alu;
        logic        rtype;
        logic [3:0]  dest;
        logic [3:0]  srcsel;
        logic [3:0]  oper;
        logic [7:0]  imm;
        logic        immen;
        logic        we;
        logic        fl;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic taken_of(input logic [3:0] c, input logic [4:0] f);
        if (c == 4'd0)  return f[1];
        if (c == 4'd1)  return !f[1];
        if (c == 4'd2)  return f[4];
        if (c == 4'd3)  return !f[4];
        if (c == 4'd14) return 1'b1;
        return 1'b0;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        instr = 16'h0000;
        src_data = 16'h0000;
        Flags = 5'h00;
        @(negedge clk);
        @(negedge clk);
        chk("rst_pc", pc, PC_RESET);
        chk("rst_halted", halted, 0);
        chk("rst_strobes", {reg_we, flagsEn, RWA, RWB, immEn}, 0);
        chk("rst_mux", {AluOrMem, AorB}, 2'b11);
        reset = 1'b0;
        m_pc = PC_RESET;
    endtask

    // Runs one instruction from its FETCH cycle; returns at the next FETCH cycle.
    task automatic do_instr(input logic [15:0] iw, input logic [15:0] src, input logic [4:0] fl);
        logic [3:0] op, rd, ext, rs;
        logic [7:0] im;
        logic [9:0] npc, ea;
        int ncyc, e_we, e_fl, e_imm, e_rwa, e_wb;
        int a_we, a_fl, a_imm, a_rwa, a_rwb, a_wb;
        op = iw[15:12]; rd = iw[11:8]; ext = iw[7:4]; rs = iw[3:0]; im = iw[7:0];
        ea = DATA_BASE + src[9:0];
        npc = m_pc + 10'd1;
        ncyc = 3; e_we = 0; e_fl = 0; e_imm = 0; e_rwa = 0; e_wb = 0;
        a_we = 0; a_fl = 0; a_imm = 0; a_rwa = 0; a_rwb = 0; a_wb = 0;
        if (op == 4'h0) begin
            e_we = 1; e_fl = 1;
        end else if (op <= 4'h7) begin
            e_fl = 1; e_imm = 1; e_we = (op != 4'h3) ? 1 : 0;
        end else if (op == 4'h8) begin
            ncyc  = (ext == 4'h0) ? 5 : 4;
            e_rwa = (ext == 4'h4) ? 1 : 0;
            e_we  = (ext == 4'h0) ? 1 : 0;
            e_wb  = e_we;
`ifdef BRANCH_EN
        end else if (op == 4'hC && taken_of(rd, fl)) begin
            npc = m_pc + {{2{im[7]}}, im};
`endif
        end
        instr = iw; src_data = src; Flags = fl;
        #1;
        for (int c = 0; c < ncyc; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 0) begin
                chk("fetch_pc", pc, m_pc);
                chk("fetch_addrb", AddressB, m_pc);
                chk("fetch_halted", halted, 0);
            end
            if (c == 2) begin
                x_dest = DestCtrl; x_src = SrcCtrl; x_op = operation; x_imm = immediate;
                x_immen = immEn; x_we = reg_we; x_fl = flagsEn;
                if (op <= 4'h7) begin
                    chk("exec_dest", DestCtrl, rd);
                    chk("exec_op", operation, (op == 4'h0) ? ext : op);
                    chk("exec_alumem", AluOrMem, 1);
                    if (op == 4'h0) chk("exec_src", SrcCtrl, rs);
                    else            chk("exec_imm", immediate, im);
                end
            end
            if (c == 3) begin
                x_addra = AddressA;
                chk("mem_addra", AddressA, ea);
                chk("mem_srcsel", SrcCtrl, rs);
            end
            if (c == 4) begin
                chk("wb_mux", {AluOrMem, AorB}, 2'b01);
                chk("wb_dest", DestCtrl, rd);
            end
            a_we += reg_we; a_fl += flagsEn; a_imm += immEn;
            a_rwa += RWA; a_rwb += RWB; a_wb += !AluOrMem;
        end
        x_rwa = a_rwa;
        chk("cnt_reg_we", a_we, e_we);
        chk("cnt_flags_en", a_fl, e_fl);
        chk("cnt_imm_en", a_imm, e_imm);
        chk("cnt_rwa", a_rwa, e_rwa);
        chk("cnt_rwb", a_rwb, 0);
        chk("cnt_wb", a_wb, e_wb);
        m_pc = npc;
        @(negedge clk);
    endtask

    vec_t vecs[6];
    logic [9:0] exp_br;

    initial begin
        vecs[0] = '{16'h0152, 1, 1, 4'h1, 4'h2, 4'h5, 8'h00, 0, 1, 1};
        vecs[1] = '{16'h1207, 1, 0, 4'h2, 4'h0, 4'h1, 8'h07, 1, 1, 1};
        vecs[2] = '{16'h3207, 1, 0, 4'h2, 4'h0, 4'h3, 8'h07, 1, 0, 1};
        vecs[3] = '{16'h0A3C, 1, 1, 4'hA, 4'hC, 4'h3, 8'h00, 0, 1, 1};
        vecs[4] = '{16'h7FFF, 1, 0, 4'hF, 4'h0, 4'h7, 8'hFF, 1, 1, 1};
        vecs[5] = '{16'h9000, 0, 0, 4'h0, 4'h0, 4'h0, 8'h00, 0, 0, 0};

        do_reset();
        for (int i = 0; i < 6; i++) begin
            do_instr(vecs[i].iw, 16'h0000, 5'h00);
            if (i == 0) chk("pc_after_first", pc, 10'd1);
            chk("tv_we", x_we, vecs[i].we);
            chk("tv_flags_en", x_fl, vecs[i].fl);
            chk("tv_imm_en", x_immen, vecs[i].immen);
            if (vecs[i].alu) begin
                chk("tv_dest", x_dest, vecs[i].dest);
                chk("tv_oper", x_op, vecs[i].oper);
            end
            if (vecs[i].rtype) chk("tv_srcsel", x_src, vecs[i].srcsel);
            if (vecs[i].immen) chk("tv_immediate", x_imm, vecs[i].imm);
        end

        do_instr(16'h8304, 16'h0010, 5'h00);
        chk("load_addra", x_addra, 10'h210);
        do_instr(16'h8344, 16'h0010, 5'h00);
        chk("store_pulses", x_rwa, 1);

`ifdef BRANCH_EN
        exp_br = 10'd3;
`else
        exp_br = 10'd6;
`endif
        do_reset();
        for (int i = 0; i < 5; i++) do_instr(16'h0000, 16'h0000, 5'h00);
        chk("br_start_pc", pc, 10'd5);
        do_instr(16'hC0FE, 16'h0000, 5'b00010);
        chk("br_z1_pc", pc, exp_br);
        do_reset();
        for (int i = 0; i < 5; i++) do_instr(16'h0000, 16'h0000, 5'h00);
        do_instr(16'hC0FE, 16'h0000, 5'b00000);
        chk("br_z0_pc", pc, 10'd6);

        // long random stream also carries pc through its 10-bit wrap
        do_reset();
        for (int i = 0; i < 1100; i++) begin
            logic [15:0] w;
            w = 16'($urandom);
            if (w[15:12] == 4'hF) w[15:12] = 4'h0;
            do_instr(w, 16'($urandom), 5'($urandom));
        end

        do_reset();
        instr = 16'h8344; src_data = 16'h0010; Flags = 5'h00;
        #1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("midmem_rwa_before", RWA, 1);
        reset = 1'b1;
        instr = 16'h0000;
        #1;
        chk("midmem_rwa_reset", RWA, 0);
        chk("midmem_pc_reset", pc, PC_RESET);
        chk("midmem_addrb", AddressB, PC_RESET);
        @(negedge clk);
        chk("midmem_rwa_hold", RWA, 0);
        reset = 1'b0;
        m_pc = PC_RESET;
        do_instr(16'h0000, 16'h0000, 5'h00);

        do_instr(16'hF000, 16'h0000, 5'h00);
        for (int i = 0; i < 20; i++) begin
            chk("halt_flag", halted, 1);
            chk("halt_strobes", {reg_we, flagsEn, RWA, RWB, immEn}, 0);
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_controller.md
CPU_CONTROLLER -- requirements
Module: cpu_controller

Interface
REQ-001 SHALL have parameter PC_RESET, default 10'h000, meaning the program-counter value loaded on reset.
REQ-002 SHALL have parameter DATA_BASE, default 10'h200, meaning the base added to the register address for loads and stores.
REQ-003 Ports: clk  in  1  single clock, all state on rising edge.
REQ-004 Ports: reset  in  1  asynchronous, active-high.
REQ-005 Ports: instr  in  16  BRAM port-B read data (fetched instruction).
REQ-006 Ports: src_data  in  16  current value of the register selected by SrcCtrl.
REQ-007 Ports: Flags  in  5  flag register {C,L,F,Z,N}, bit 4 = C.
REQ-008 Ports: DestCtrl, SrcCtrl, operation  out  4 each  register selects and ALU opcode.
REQ-009 Ports: immediate  out  8; immEn, flagsEn, reg_we  out  1 each.
REQ-010 Ports: AddressA, AddressB  out  10; RWA, RWB, AorB, AluOrMem  out  1 each.
REQ-011 Ports: pc  out  10  program counter; halted  out  1  high once HALT executes.

Function
REQ-012 SHALL be a Moore FSM with states FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-013 FETCH SHALL drive AddressB=pc and RWB=0, then go to DECODE (BRAM read latency is 1 cycle).
REQ-014 DECODE SHALL latch instr into IR, then go to EXEC.
REQ-015 Decode: op=IR[15:12], rd=IR[11:8], ext=IR[7:4], rs=IR[3:0], imm=IR[7:0].
REQ-016 For op 4'h0 (R-type), EXEC SHALL drive DestCtrl=rd, SrcCtrl=rs, operation=ext, immEn=0, AluOrMem=1, reg_we=1 and flagsEn=1.
REQ-017 For op 4'h1–4'h7 (I-type), EXEC SHALL drive DestCtrl=rd, operation=op, immediate=imm, immEn=1, AluOrMem=1, reg_we=1 and flagsEn=1.
REQ-018 I-type op 4'h3 (CMP) SHALL drive reg_we=0 with flagsEn=1.
REQ-019 For op 4'h8 (memory), EXEC SHALL go to MEM.
REQ-020 In MEM: AddressA=DATA_BASE+src_data[9:0] with 10-bit wrap, SrcCtrl=rs, DestCtrl=rd.
REQ-021 In MEM, ext 4'h0 (LOAD) SHALL drive RWA=0 and go to WB.
REQ-022 In MEM, ext 4'h4 (STORE) SHALL drive RWA=1 for exactly one cycle and go to FETCH.
REQ-023 In MEM, any other ext SHALL go to FETCH with no write.
REQ-024 WB SHALL drive AluOrMem=0, AorB=1, DestCtrl=rd, reg_we=1 for one cycle, then go to FETCH.
REQ-025 pc SHALL increment by 1 (10-bit wrap, 10'h3FF->10'h000) on the EXEC cycle unless a branch is taken.
REQ-026 Op 4'hF SHALL enter HALT.
REQ-027 HALT SHALL assert halted and hold all write strobes low until reset.
REQ-028 Undefined opcodes SHALL execute as NOP: pc+1, no strobes.
REQ-029 Outside its listed states, every strobe (reg_we, flagsEn, RWA, RWB, immEn) SHALL be 0.
REQ-030 Outside its listed states, AluOrMem SHALL be 1 and AorB SHALL be 1.

Reset
REQ-031 Reset SHALL asynchronously force state=FETCH, pc=PC_RESET, IR=16'h0000, halted=0 and all strobes 0.
REQ-032 Reset asserted during MEM or WB SHALL abort the access, with no write issued on the reset cycle.

Configuration
REQ-033 With BRANCH_EN defined, op 4'hC (Bcond, cond=rd, disp=imm signed) SHALL add sign-extended disp to pc in EXEC when taken, otherwise pc+1.
REQ-034 Bcond SHALL be taken for cond EQ(0)=Z, NE(1)=!Z, CS(2)=C, CC(3)=!C and UC(4'hE)=1.
REQ-035 Bcond SHALL be not taken for every other cond value.
REQ-036 Without BRANCH_EN, op 4'hC SHALL execute as NOP.

Structure
REQ-037 Package cpu_pkg SHALL hold the state enum, opcode/ext constants, flag bit indices and cond codes.
REQ-038 Sub-module branch_cond SHALL map (cond, Flags) to taken and SHALL be instantiated only under BRANCH_EN.

Verification
REQ-039 Reset then instr=16'h0152 (R-type) -> EXEC: DestCtrl=1, SrcCtrl=2, operation=5, reg_we=1, flagsEn=1; pc 0->1.
REQ-040 instr=16'h1207 -> immEn=1, immediate=8'h07, operation=1, DestCtrl=2.
REQ-041 instr=16'h3207 -> reg_we=0, flagsEn=1.
REQ-042 LOAD 16'h8304, src_data=16'h0010 -> MEM: AddressA=10'h210, RWA=0; WB: AluOrMem=0, AorB=1, DestCtrl=3, reg_we=1.
REQ-043 STORE 16'h8344 -> exactly one RWA=1 cycle.
REQ-044 BRANCH_EN with pc=5: Flags Z=1 and instr=16'hC0FE -> pc=3; Z=0 -> pc=6.
REQ-045 16'hF000 -> halted=1 with no strobes for 20 cycles.
REQ-046 Reset pulsed mid-MEM -> FETCH with pc=PC_RESET and no RWA pulse.
